// File: rtl/exmem_stage_if.sv
// EX/MEM stage bundle: upstream beat with valid/ready, downstream head with
// valid/ready, and the stall counter used for performance debug.
interface exmem_stage_if #(
    parameter int DATA_W     = 32,
    parameter int WB_W       = 2,
    parameter int MEM_W      = 3,
    parameter int REGADDR_W  = 5,
    parameter int STALLCNT_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WB_W-1:0]       WB_IN;
    logic [MEM_W-1:0]      MEM_IN;
    logic [DATA_W-1:0]     BranchPC_IN;
    logic [DATA_W-1:0]     AluResult_IN;
    logic [DATA_W-1:0]     RD2_IN;
    logic                  Zero_IN;
    logic [REGADDR_W-1:0]  WR_IN;

    logic                  out_valid;
    logic                  out_ready;
    logic [WB_W-1:0]       WB_OUT;
    logic [MEM_W-1:0]      MEM_OUT;
    logic [DATA_W-1:0]     BranchPC_OUT;
    logic [DATA_W-1:0]     AluResult_OUT;
    logic [DATA_W-1:0]     RD2_OUT;
    logic                  Zero_OUT;
    logic [REGADDR_W-1:0]  WR_OUT;
    logic [STALLCNT_W-1:0] StallCount;

    // Environment side: EX stage producer plus MEM stage consumer.
    modport master (
        output in_valid, WB_IN, MEM_IN, BranchPC_IN, AluResult_IN, RD2_IN, Zero_IN, WR_IN,
        output out_ready,
        input  in_ready,
        input  out_valid, WB_OUT, MEM_OUT, BranchPC_OUT, AluResult_OUT, RD2_OUT, Zero_OUT, WR_OUT,
        input  StallCount
    );

    modport slave (
        input  in_valid, WB_IN, MEM_IN, BranchPC_IN, AluResult_IN, RD2_IN, Zero_IN, WR_IN,
        input  out_ready,
        output in_ready,
        output out_valid, WB_OUT, MEM_OUT, BranchPC_OUT, AluResult_OUT, RD2_OUT, Zero_OUT, WR_OUT,
        output StallCount
    );
endinterface

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush-to-bubble and a
// saturating stall counter. Define EXMEM_SKID_EN for the two-entry elastic build.
module exmem_stage #(
    parameter int DATA_W     = 32,
    parameter int WB_W       = 2,
    parameter int MEM_W      = 3,
    parameter int REGADDR_W  = 5,
    parameter int STALLCNT_W = 16
) (
    input logic          Clk,
    input logic          Rst,
    input logic          Flush,
    exmem_stage_if.slave bus
);

    typedef struct packed {
        logic [WB_W-1:0]      wb;
        logic [MEM_W-1:0]     mem;
        logic [DATA_W-1:0]    bpc;
        logic [DATA_W-1:0]    alu;
        logic [DATA_W-1:0]    rd2;
        logic                 zero;
        logic [REGADDR_W-1:0] wr;
    } entry_t;

    function automatic logic [STALLCNT_W-1:0] sat_inc(input logic [STALLCNT_W-1:0] v);
        return (&v) ? v : v + {{(STALLCNT_W-1){1'b0}}, 1'b1};
    endfunction

    // A bubble must never write the register file or memory; datapath holds.
    function automatic entry_t bubble_mask(input entry_t e, input logic v);
        entry_t r;
        r = e;
        if (!v) begin
            r.wb  = '0;
            r.mem = '0;
        end
        return r;
    endfunction

    entry_t                in_beat;
    entry_t                main_p0;
    entry_t                head;
    logic                  vld_p0;
    logic                  accept;
    logic                  xfer;
    logic                  stall;
    logic [STALLCNT_W-1:0] stall_cnt_p0;

    assign in_beat = '{wb:   bus.WB_IN,
                       mem:  bus.MEM_IN,
                       bpc:  bus.BranchPC_IN,
                       alu:  bus.AluResult_IN,
                       rd2:  bus.RD2_IN,
                       zero: bus.Zero_IN,
                       wr:   bus.WR_IN};

    assign accept = bus.in_valid && bus.in_ready;
    assign xfer   = vld_p0 && bus.out_ready;
    assign stall  = vld_p0 && !bus.out_ready;

`ifdef EXMEM_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state_p0;
    state_t state_nxt;
    entry_t skid_p0;
    logic   rdy_p0;
    logic   load_main;
    logic   load_skid;
    logic   main_from_skid;

    always_comb begin
        state_nxt      = state_p0;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (Flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state_p0)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !xfer) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (accept && xfer) begin
                        load_main = 1'b1;
                    end else if (xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        state_nxt      = ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // ---- stage boundary: EX bundle captured into main/skid ----
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_p0 <= EMPTY;
            rdy_p0   <= 1'b1;
            main_p0  <= '0;
            skid_p0  <= '0;
        end else begin
            state_p0 <= state_nxt;
            // Registered ready: only the next state decides, never out_ready directly.
            rdy_p0   <= (state_nxt != TWO);
            if (load_main) begin
                main_p0 <= in_beat;
            end else if (main_from_skid) begin
                main_p0 <= skid_p0;
            end
            if (load_skid) begin
                skid_p0 <= in_beat;
            end
        end
    end

    assign vld_p0       = (state_p0 != EMPTY);
    assign bus.in_ready = rdy_p0;
`else
    // ---- stage boundary: EX bundle captured into the single entry ----
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_p0  <= 1'b0;
            main_p0 <= '0;
        end else if (Flush) begin
            vld_p0 <= 1'b0;
        end else if (accept) begin
            main_p0 <= in_beat;
            vld_p0  <= 1'b1;
        end else if (xfer) begin
            vld_p0 <= 1'b0;
        end
    end

    assign bus.in_ready = !vld_p0 || bus.out_ready;
`endif

    // Survives Flush on purpose so stalls around redirects stay visible.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_p0 <= '0;
        end else if (stall) begin
            stall_cnt_p0 <= sat_inc(stall_cnt_p0);
        end
    end

    assign head              = bubble_mask(main_p0, vld_p0);
    assign bus.out_valid     = vld_p0;
    assign bus.WB_OUT        = head.wb;
    assign bus.MEM_OUT       = head.mem;
    assign bus.BranchPC_OUT  = head.bpc;
    assign bus.AluResult_OUT = head.alu;
    assign bus.RD2_OUT       = head.rd2;
    assign bus.Zero_OUT      = head.zero;
    assign bus.WR_OUT        = head.wr;
    assign bus.StallCount    = stall_cnt_p0;

endmodule

// File: doc/exmem_stage.md
# exmem_stage

Parametrised successor of the fixed EX/MEM pipeline register. It carries the EX-stage bundle (WB control, MEM control, branch target, ALU result, store data, Zero flag, write-register index) into the MEM stage. It adds synchronous reset, a valid/ready handshake for stalls, and a flush that converts in-flight entries into bubbles. Bubbles present zeroed control fields downstream, and a saturating counter records stall cycles for performance debug.

## Interface
- DATA_W, 32, width of BranchPC, AluResult and RD2
- WB_W, 2, width of the WB control field
- MEM_W, 3, width of the MEM control field
- REGADDR_W, 5, width of the write-register index
- STALLCNT_W, 16, width of the stall counter
- Clk  input  1  clock, all state updates on the rising edge
- Rst  input  1  reset; synchronous, active-high
- Flush  input  1  discard all held entries (branch redirect / exception)
- in_valid  input  1  EX stage presents a beat
- in_ready  output  1  stage can accept a beat this cycle
- WB_IN, MEM_IN  input  WB_W, MEM_W  control fields
- BranchPC_IN, AluResult_IN, RD2_IN  input  DATA_W  datapath fields
- Zero_IN  input  1  ALU zero flag
- WR_IN  input  REGADDR_W  destination register
- out_valid  output  1  MEM stage sees a real instruction
- out_ready  input  1  MEM stage consumes the head this cycle
- WB_OUT, MEM_OUT, BranchPC_OUT, AluResult_OUT, RD2_OUT, Zero_OUT, WR_OUT  output  matching widths  head entry fields
- StallCount  output  STALLCNT_W  saturating count of cycles with out_valid && !out_ready

## Operation
- Accept on in_valid && in_ready. Transfer out on out_valid && out_ready.
- Head entry drives all *_OUT ports.
- When out_valid=0, WB_OUT and MEM_OUT read 0, so a bubble never writes the register file or memory. BranchPC_OUT, AluResult_OUT, RD2_OUT, Zero_OUT and WR_OUT hold their last value.
- Priority is Rst > Flush > handshake.
- Flush empties the stage at the next edge. A beat offered in the flush cycle is dropped, even if in_ready=1.
- Storage without skid: one entry. It is EMPTY or FULL. in_ready = !out_valid || out_ready (combinational).
- Storage with skid: main entry plus one skid entry. States are EMPTY, ONE and TWO.
  - EMPTY: on accept, go to ONE.
  - ONE: accept without transfer goes to TWO, with the new beat in skid. Transfer without accept goes to EMPTY. Both at once stays in ONE and loads the new beat into main.
  - TWO: in_ready=0. On transfer, skid moves to main and the state goes to ONE.
- StallCount increments by 1 per stall cycle and saturates at all-ones. It is not cleared by Flush and is cleared only by Rst.
- No arithmetic on datapath fields. Widths pass through unchanged.

## Timing
- Latency: a beat accepted at edge N is visible on *_OUT with out_valid=1 after edge N.
- Throughput: one beat per cycle while out_ready=1.
- Reset values (next edge after Rst=1):
  - out_valid=0 and all *_OUT=0
  - StallCount=0
  - skid state EMPTY
  - in_ready=1 from the cycle after reset deasserts
- Rst asserted mid-transfer discards every entry. No partial beat survives.
- Flush with out_ready=1 on a valid head: that head still counts as consumed by MEM in that cycle. Afterwards out_valid=0.
- With skid, in_ready is a register output with no combinational path from out_ready. Without skid, a combinational out_ready -> in_ready path exists.

## Configuration
- EXMEM_SKID_EN defined: two-entry elastic stage, registered in_ready, and full throughput across back-pressure boundaries.
- EXMEM_SKID_EN undefined: single register with combinational ready, which is the minimal area option.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold Rst=1 for 2 cycles with in_valid=1 and AluResult_IN=32'hDEADBEEF.
  - Required: out_valid=0, all outputs 0, StallCount=0.
  - First beat is accepted only after Rst falls.
- Streaming: 8 back-to-back beats with AluResult_IN=1..8, WB_IN=2'b10, out_ready=1.
  - Required: outputs 1..8 on consecutive cycles, each one cycle after its accept, no gaps.
- Back-pressure: out_ready=0 for 5 cycles while a beat with WR_IN=5'd7 is held.
  - Required: WR_OUT stays 7 and StallCount=5.
  - With EXMEM_SKID_EN, exactly one more beat is accepted before in_ready=0.
  - Release out_ready: beats emerge in order, none lost or duplicated.
- Flush: hold 2 entries (skid build) or 1 entry, then assert Flush with in_valid=1 and MEM_IN=3'b011.
  - Required: next cycle out_valid=0 with MEM_OUT=0 and WB_OUT=0, and the flushed-cycle beat never appears.
- Saturation: with STALLCNT_W=4, stall for 20 cycles.
  - Required: StallCount=4'hF and holds there.
  - A subsequent Flush leaves it at 4'hF. Rst clears it to 0.
